// File: rtl/spi_regfile_pkg.sv
// Shared types and helpers for the SPI register-file peripheral.
//   state_t   : frame FSM states
//   RW_WRITE  : value of the R/W bit that selects a write frame
//   cnt_width : bit-counter width for the wider of the address and data fields
package spi_regfile_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    DONE
  } state_t;

  localparam logic RW_WRITE = 1'b1;

  // The counter only needs to hold max(a,b)-1. The result is kept at least 1 bit wide.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchroniser for one asynchronous pad input, plus single-clk edge pulses.
//   clk, rst_n : system clock, synchronous active-low reset
//   din        : asynchronous input
//   level      : synchronised level (after SYNC_STAGES flops)
//   rise, fall : 1-clk pulses on synchronised level transitions
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   hist_p1;

  // The chain resets to 0 so that a reset taken while nCS is low produces no
  // falling edge. The FSM then waits for the next real nCS assertion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      hist_p1 <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
      hist_p1 <= sync_p0[SYNC_STAGES-1];
    end
  end

  assign level = sync_p0[SYNC_STAGES-1];
  assign rise  = level & ~hist_p1;
  assign fall  = ~level & hist_p1;

endmodule

// File: rtl/spi_regfile_slave.sv
// SPI mode-0 peripheral with a NUM_REGS x DATA_W register bank, with write and read-back.
// The frame is sent MSB first: R/W bit (1=write), ADDR_W address bits, then DATA_W data bits.
//   clk, rst_n        : system clock (>= 8x SCLK), synchronous active-low reset
//   SCLK, COPI, nCS   : asynchronous SPI pad inputs
//   CIPO, CIPO_oe     : SPI data out and its pad output enable
//   regs_q            : register bank, reg k at [k*DATA_W +: DATA_W]
//   wr_pulse, wr_addr : 1-clk commit strobe and the address that was committed
module spi_regfile_slave
  import spi_regfile_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       SCLK,
  input  logic                       COPI,
  input  logic                       nCS,
  output logic                       CIPO,
  output logic                       CIPO_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_q,
  output logic                       wr_pulse,
  output logic [ADDR_W-1:0]          wr_addr
);

  localparam int              CNT_W      = cnt_width(ADDR_W, DATA_W);
  localparam logic [ADDR_W:0] NUM_REGS_V = (ADDR_W+1)'(NUM_REGS);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic copi_lvl, copi_rise, copi_fall;
  logic ncs_lvl, ncs_rise, ncs_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(SCLK), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .din(COPI), .level(copi_lvl), .rise(copi_rise), .fall(copi_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .din(nCS), .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
  );

  // These synchroniser outputs are not needed by this block.
  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_lvl, copi_rise, copi_fall, ncs_lvl};

  state_t             state;
  logic [CNT_W-1:0]   bitcnt;
  logic               rw_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic [DATA_W-1:0]  rd_sh;
  logic [DATA_W-1:0]  regs_arr [NUM_REGS];

  logic [ADDR_W-1:0]  addr_nx;
  logic [DATA_W-1:0]  data_nx;
  logic [DATA_W-1:0]  rd_word;
  logic               addr_ok;

  assign addr_nx = ADDR_W'({addr_q, copi_lvl});
  assign data_nx = DATA_W'({data_q, copi_lvl});
  assign addr_ok = ({1'b0, addr_q} < NUM_REGS_V);

  // The read word is looked up with the address that includes the bit being
  // sampled now, so that it is ready before the first data falling edge.
  // An unimplemented address reads back as 0.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (addr_nx == ADDR_W'(k)) rd_word = regs_arr[k];
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
    assign regs_q[k*DATA_W +: DATA_W] = regs_arr[k];
  end

  // Address/data/read shift registers. These are fully reloaded by every
  // frame before they are used, so they take no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && ncs_fall) begin
      addr_q <= '0;
      data_q <= '0;
      rd_sh  <= '0;
    end else if (state == ADDR && sclk_rise) begin
      addr_q <= addr_nx;
      if (bitcnt == '0 && rw_q != RW_WRITE) rd_sh <= rd_word;
    end else if (state == DATA && sclk_rise) begin
      data_q <= data_nx;
    end else if (state == DATA && sclk_fall && rw_q != RW_WRITE) begin
      rd_sh <= rd_sh << 1;
    end
  end

  // Frame FSM, register bank and registered pad outputs.
  // ncs_rise has priority over any sclk edge in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      bitcnt   <= '0;
      rw_q     <= 1'b0;
      CIPO     <= 1'b0;
      CIPO_oe  <= 1'b0;
      wr_pulse <= 1'b0;
      wr_addr  <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs_arr[k] <= '0;
    end else begin
      wr_pulse <= 1'b0;
      if (ncs_rise) begin
        state   <= IDLE;
        CIPO    <= 1'b0;
        CIPO_oe <= 1'b0;
        // Commit only a complete write frame with an implemented address.
        if (state == DONE && rw_q == RW_WRITE && addr_ok) begin
          wr_pulse <= 1'b1;
          wr_addr  <= addr_q;
          for (int k = 0; k < NUM_REGS; k++) begin
            if (addr_q == ADDR_W'(k)) regs_arr[k] <= data_q;
          end
        end
      end else begin
        if (ncs_fall) CIPO_oe <= 1'b1;
        case (state)
          IDLE: begin
            CIPO <= 1'b0;
            if (ncs_fall) state <= CMD;
          end
          CMD: begin
            if (sclk_rise) begin
              rw_q   <= copi_lvl;
              bitcnt <= CNT_W'(ADDR_W - 1);
              state  <= ADDR;
            end
          end
          ADDR: begin
            if (sclk_rise) begin
              if (bitcnt == '0) begin
                bitcnt <= CNT_W'(DATA_W - 1);
                state  <= DATA;
              end else begin
                bitcnt <= bitcnt - 1'b1;
              end
            end
          end
          DATA: begin
            if (sclk_rise) begin
              if (bitcnt == '0) state <= DONE;
              else              bitcnt <= bitcnt - 1'b1;
            end
            // The first falling edge presents the MSB. Each later falling edge
            // presents the next bit.
            if (sclk_fall && rw_q != RW_WRITE) CIPO <= rd_sh[DATA_W-1];
          end
          DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
